// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the regfile write port between the ALU (req0) and load (req1) writebacks.
// Define REGFILE_ARB_FWD_EN to add a combinational write-to-read bypass on two read ports.
`ifndef WORD
`define WORD 64
`endif

module regfile_write_arbiter #(
  parameter int          WIDTH = `WORD,
  parameter int unsigned XZR   = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [4:0]       req0_reg,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [4:0]       req1_reg,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             hold,
`ifdef REGFILE_ARB_FWD_EN
  input  logic [4:0]       rd_reg1,
  input  logic [4:0]       rd_reg2,
  input  logic [WIDTH-1:0] rf_data1,
  input  logic [WIDTH-1:0] rf_data2,
  output logic [WIDTH-1:0] fwd_data1,
  output logic [WIDTH-1:0] fwd_data2,
`endif
  output logic             RegWrite,
  output logic [4:0]       write_register,
  output logic [WIDTH-1:0] write_data,
  output logic             last_grant
);

  localparam logic [4:0] XZR_IDX = XZR[4:0];
  localparam logic       PRI0    = 1'b0;
  localparam logic       PRI1    = 1'b1;

  logic             state_q, state_d;
  logic             regwrite_q, regwrite_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             grant0, grant1;

  // Arbitration: a lone requester always wins, otherwise the pointer decides.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && !hold) begin
      if (req0_valid && (!req1_valid || state_q == PRI0)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    state_d    = state_q;
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    if (grant0) begin
      state_d    = PRI1;
      regwrite_d = (req0_reg != XZR_IDX);
      wreg_d     = req0_reg;
      wdata_d    = req0_data;
    end else if (grant1) begin
      state_d    = PRI0;
      regwrite_d = (req1_reg != XZR_IDX);
      wreg_d     = req1_reg;
      wdata_d    = req1_data;
    end
  end

  // Output stage: one registered write per accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= PRI0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  assign RegWrite       = regwrite_q;
  assign write_register = wreg_q;
  assign write_data     = wdata_q;
  // PRI0 means requester 1 was served last.
  assign last_grant     = (state_q == PRI0);

`ifdef REGFILE_ARB_FWD_EN
  assign fwd_data1 = (regwrite_q && wreg_q == rd_reg1 && rd_reg1 != XZR_IDX) ? wdata_q : rf_data1;
  assign fwd_data2 = (regwrite_q && wreg_q == rd_reg2 && rd_reg2 != XZR_IDX) ? wdata_q : rf_data2;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_regfile_write_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         v0, v1, hold;
  logic [4:0]   r0reg, r1reg;
  logic [W-1:0] d0, d1;
  logic         rdy0, rdy1, rw, lg;
  logic [4:0]   wreg;
  logic [W-1:0] wdata;
`ifdef REGFILE_ARB_FWD_EN
  logic [4:0]   rd1, rd2;
  logic [W-1:0] rf1, rf2, fw1, fw2;
`endif

  int tests = 0;
  int failed = 0;

  // Behavioural model state
  int           m_pref;   // index of preferred requester
  logic         m_g0, m_g1, m_rw, m_last;
  logic [4:0]   m_reg;
  logic [W-1:0] m_data;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.WIDTH(W), .XZR(31)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_ready(rdy0), .req0_reg(r0reg), .req0_data(d0),
    .req1_valid(v1), .req1_ready(rdy1), .req1_reg(r1reg), .req1_data(d1),
    .hold(hold),
`ifdef REGFILE_ARB_FWD_EN
    .rd_reg1(rd1), .rd_reg2(rd2), .rf_data1(rf1), .rf_data2(rf2),
    .fwd_data1(fw1), .fwd_data2(fw2),
`endif
    .RegWrite(rw), .write_register(wreg), .write_data(wdata), .last_grant(lg)
  );

  task automatic model_grant();
    m_g0 = 1'b0;
    m_g1 = 1'b0;
    if (!reset && !hold) begin
      if (v0 && v1) begin
        if (m_pref == 0) m_g0 = 1'b1; else m_g1 = 1'b1;
      end else if (v0) m_g0 = 1'b1;
      else if (v1) m_g1 = 1'b1;
    end
  endtask

  task automatic model_clock();
    if (reset) begin
      m_pref = 0; m_last = 1'b1; m_rw = 1'b0; m_reg = '0; m_data = '0;
    end else if (m_g0) begin
      m_pref = 1; m_last = 1'b0; m_rw = (r0reg != 5'd31); m_reg = r0reg; m_data = d0;
    end else if (m_g1) begin
      m_pref = 0; m_last = 1'b1; m_rw = (r1reg != 5'd31); m_reg = r1reg; m_data = d1;
    end else begin
      m_rw = 1'b0;
    end
  endtask

  task automatic drive(input logic rst, input logic h, input logic a0, input logic [4:0] g0,
                       input logic [W-1:0] x0, input logic a1, input logic [4:0] g1,
                       input logic [W-1:0] x1);
    reset = rst; hold = h;
    v0 = a0; r0reg = g0; d0 = x0;
    v1 = a1; r1reg = g1; d1 = x1;
    model_grant();
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    tick();
    #3;
    tests++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin failed++; $display("FAIL reset_ready: got %b%b want 00", rdy0, rdy1); end
    tests++; if (rw !== 1'b0) begin failed++; $display("FAIL reset_regwrite: got %b want 0", rw); end
    tests++; if (wreg !== 5'd0 || wdata !== '0) begin failed++; $display("FAIL reset_outputs: got reg=%0d data=%0d want 0 0", wreg, wdata); end
    tests++; if (lg !== 1'b1) begin failed++; $display("FAIL reset_last_grant: got %b want 1", lg); end
    tick();
  endtask

  task automatic test_single();
    drive(1'b0, 1'b0, 1'b1, 5'd13, 32'd4783, 1'b0, 5'd0, '0);
    #3;
    tests++; if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin failed++; $display("FAIL single_ready: got %b%b want 10", rdy0, rdy1); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    #3;
    tests++; if (rw !== 1'b1) begin failed++; $display("FAIL single_regwrite: got %b want 1", rw); end
    tests++; if (wreg !== 5'd13 || wdata !== 32'd4783) begin failed++; $display("FAIL single_data: got reg=%0d data=%0d want 13 4783", wreg, wdata); end
    tick();
    #3;
    tests++; if (rw !== 1'b0) begin failed++; $display("FAIL single_pulse_end: got %b want 0", rw); end
    tests++; if (wreg !== 5'd13 || wdata !== 32'd4783) begin failed++; $display("FAIL single_retain: got reg=%0d data=%0d want 13 4783", wreg, wdata); end
    tick();
  endtask

  task automatic test_round_robin();
    logic       e0;
    logic [4:0] er;
    drive(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, k < 4, 5'd1, 32'd100 + k, k < 4, 5'd2, 32'd200 + k);
      #3;
      e0 = (k < 4) && (k % 2 == 0);
      tests++; if (rdy0 !== e0 || rdy1 !== ((k < 4) && !e0)) begin failed++; $display("FAIL rr_grant[%0d]: got %b%b want %b%b", k, rdy0, rdy1, e0, (k < 4) && !e0); end
      tests++; if (rw !== (k >= 1 && k <= 4)) begin failed++; $display("FAIL rr_regwrite[%0d]: got %b want %b", k, rw, (k >= 1 && k <= 4)); end
      if (k >= 1 && k <= 4) begin
        er = ((k - 1) % 2 == 0) ? 5'd1 : 5'd2;
        tests++; if (wreg !== er) begin failed++; $display("FAIL rr_reg[%0d]: got %0d want %0d", k, wreg, er); end
      end
      tick();
    end
  endtask

  task automatic test_xzr();
    drive(1'b0, 1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd31, 32'd3987);
    #3;
    tests++; if (rdy1 !== 1'b1 || rdy0 !== 1'b0) begin failed++; $display("FAIL xzr_ready: got %b%b want 01", rdy0, rdy1); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    #3;
    tests++; if (rw !== 1'b0) begin failed++; $display("FAIL xzr_regwrite: got %b want 0", rw); end
    tests++; if (lg !== 1'b1) begin failed++; $display("FAIL xzr_last_grant: got %b want 1", lg); end
    tick();
  endtask

  task automatic test_hold();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b1, 5'd6, 32'd66, 1'b1, 5'd7, 32'd77);
      #3;
      tests++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin failed++; $display("FAIL hold_ready[%0d]: got %b%b want 00", k, rdy0, rdy1); end
      if (k > 0) begin
        tests++; if (rw !== 1'b0) begin failed++; $display("FAIL hold_regwrite[%0d]: got %b want 0", k, rw); end
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 5'd6, 32'd66, 1'b1, 5'd7, 32'd77);
    #3;
    tests++; if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin failed++; $display("FAIL hold_release: got %b%b want 10", rdy0, rdy1); end
    tick();
    drive(1'b0, 1'b1, 1'b0, 5'd0, '0, 1'b1, 5'd7, 32'd77);
    #3;
    tests++; if (rw !== 1'b1 || wreg !== 5'd6 || wdata !== 32'd66) begin failed++; $display("FAIL hold_drain: got rw=%b reg=%0d data=%0d want 1 6 66", rw, wreg, wdata); end
    tests++; if (rdy1 !== 1'b0) begin failed++; $display("FAIL hold_drain_ready: got %b want 0", rdy1); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b1, 5'd12, 32'd555, 1'b0, 5'd0, '0);
    #3;
    tests++; if (rdy0 !== 1'b0) begin failed++; $display("FAIL rstmid_ready: got %b want 0", rdy0); end
    tick();
    drive(1'b0, 1'b0, 1'b1, 5'd12, 32'd555, 1'b1, 5'd14, 32'd666);
    #3;
    tests++; if (rw !== 1'b0 || wreg !== 5'd0 || wdata !== '0) begin failed++; $display("FAIL rstmid_outputs: got rw=%b reg=%0d data=%0d want 0 0 0", rw, wreg, wdata); end
    tests++; if (lg !== 1'b1 || rdy0 !== 1'b1 || rdy1 !== 1'b0) begin failed++; $display("FAIL rstmid_pointer: got lg=%b rdy=%b%b want 1 10", lg, rdy0, rdy1); end
    tick();
  endtask

`ifdef REGFILE_ARB_FWD_EN
  task automatic test_fwd();
    rd1 = 5'd9; rd2 = 5'd31; rf1 = 32'd5; rf2 = 32'd1234;
    drive(1'b0, 1'b0, 1'b1, 5'd9, 32'd77, 1'b0, 5'd0, '0);
    #3;
    tests++; if (fw1 !== 32'd5) begin failed++; $display("FAIL fwd_idle: got %0d want 5", fw1); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    #3;
    tests++; if (fw1 !== 32'd77) begin failed++; $display("FAIL fwd_hit: got %0d want 77", fw1); end
    tests++; if (fw2 !== 32'd1234) begin failed++; $display("FAIL fwd_xzr: got %0d want 1234", fw2); end
    tick();
  endtask
`endif

  task automatic test_random();
    logic p0 = 1'b0, p1 = 1'b0;
    logic a0, a1, rs, h;
    logic [4:0] g0, g1;
    logic [W-1:0] x0, x1;
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 29) == 0);
      h  = ($urandom_range(0, 4) == 0);
      if (p0) begin a0 = 1'b1; g0 = r0reg; x0 = d0; end
      else begin
        a0 = $urandom_range(0, 1);
        g0 = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        x0 = $urandom;
      end
      if (p1) begin a1 = 1'b1; g1 = r1reg; x1 = d1; end
      else begin
        a1 = $urandom_range(0, 1);
        g1 = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        x1 = $urandom;
      end
      drive(rs, h, a0, g0, x0, a1, g1, x1);
      #3;
      tests++; if (rdy0 !== m_g0 || rdy1 !== m_g1) begin failed++; $display("FAIL rand_ready[%0d]: got %b%b want %b%b", i, rdy0, rdy1, m_g0, m_g1); end
      tests++; if (rw !== m_rw) begin failed++; $display("FAIL rand_regwrite[%0d]: got %b want %b", i, rw, m_rw); end
      tests++; if (wreg !== m_reg || wdata !== m_data) begin failed++; $display("FAIL rand_out[%0d]: got %0d/%0h want %0d/%0h", i, wreg, wdata, m_reg, m_data); end
      tests++; if (lg !== m_last) begin failed++; $display("FAIL rand_last_grant[%0d]: got %b want %b", i, lg, m_last); end
      p0 = a0 && !m_g0;
      p1 = a1 && !m_g1;
      tick();
    end
  endtask

  initial begin
    m_pref = 0; m_last = 1'b1; m_rw = 1'b0; m_reg = '0; m_data = '0;
`ifdef REGFILE_ARB_FWD_EN
    rd1 = '0; rd2 = '0; rf1 = '0; rf2 = '0;
`endif
    drive(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    test_reset();
    test_single();
    test_round_robin();
    test_xzr();
    test_hold();
    test_reset_mid();
`ifdef REGFILE_ARB_FWD_EN
    test_fwd();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
